serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl.sv | 118 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: two half-adder cells plus an OR form a one-bit
// full-adder slice fed LSB-first from operand shift registers by a small FSM.

module ha_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [1:0]       state_r;
  logic [1:0]       state_nx_s;
  logic             load_s;
  logic             last_s;
  logic [WIDTH-1:0] sh_a_r;
  logic [WIDTH-1:0] sh_b_r;
  // Only the upper WIDTH-1 partial-sum bits are kept; the bit that would
  // shift out on the final cycle goes straight into sum_out.
  logic [WIDTH-2:0] sh_sum_r;
  logic [WIDTH-1:0] sh_sum_nx_s;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic             p_s;
  logic             g_s;
  logic             s_s;
  logic             t_s;
  logic             c_s;

  ha_cell u_ha_0 (.a(sh_a_r[0]), .b(sh_b_r[0]), .s(p_s), .c(g_s));
  ha_cell u_ha_1 (.a(p_s),       .b(carry_r),   .s(s_s), .c(t_s));

  assign c_s         = g_s | t_s;
  assign sh_sum_nx_s = {s_s, sh_sum_r};
  assign last_s      = (cnt_r == LAST_CNT);

  // Next-state and operand-load decision.
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start_in) begin
          load_s     = 1'b1;
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State, datapath shift registers and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r   <= IDLE;
      sh_a_r    <= '0;
      sh_b_r    <= '0;
      sh_sum_r  <= '0;
      carry_r   <= 1'b0;
      cnt_r     <= '0;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
      sum_out   <= '0;
      carry_out <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      busy_out <= (state_nx_s == RUN);
      done_out <= (state_nx_s == DONE);
      if (load_s) begin
        sh_a_r   <= a_in;
        sh_b_r   <= b_in;
        sh_sum_r <= '0;
        carry_r  <= 1'b0;
        cnt_r    <= '0;
      end else if (state_r == RUN) begin
        sh_a_r   <= {1'b0, sh_a_r[WIDTH-1:1]};
        sh_b_r   <= {1'b0, sh_b_r[WIDTH-1:1]};
        sh_sum_r <= sh_sum_nx_s[WIDTH-1:1];
        carry_r  <= c_s;
        cnt_r    <= cnt_r + CW'(1);
        if (last_s) begin
          sum_out   <= sh_sum_nx_s;
          carry_out <= c_s;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=2.

module tb_serial_adder_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       st8, st2;
  logic [7:0] a8, b8, sum8;
  logic [1:0] a2, b2, sum2;
  logic       busy8, done8, co8;
  logic       busy2, done2, co2;

  int n_cmp = 0;
  int n_err = 0;
  int q8[$];
  int q2[$];
  int m_state[2] = '{0, 0};  // 0 idle, 1 run, 2 done
  int m_cnt[2]   = '{0, 0};
  int m_hold[2]  = '{0, 0};

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk_in(clk), .rst_in(rst), .start_in(st8), .a_in(a8), .b_in(b8),
    .busy_out(busy8), .done_out(done8), .sum_out(sum8), .carry_out(co8)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk_in(clk), .rst_in(rst), .start_in(st2), .a_in(a2), .b_in(b2),
    .busy_out(busy2), .done_out(done2), .sum_out(sum2), .carry_out(co2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare one instance against the model, then advance the model with the
  // inputs that the next rising edge will sample.
  task automatic mon(input int k, input logic busy, input logic done,
                     input logic [7:0] sum, input logic co, input logic r,
                     input logic st, input logic [7:0] a, input logic [7:0] b);
    int w;
    int mask;
    int qs;
    string p;
    w    = (k == 0) ? 8 : 2;
    mask = (1 << w) - 1;
    p    = $sformatf("w%0d", w);
    qs   = (k == 0) ? q8.size() : q2.size();
    check({p, "_busy"}, 32'(busy), 32'(m_state[k] == 1));
    check({p, "_done"}, 32'(done), 32'(m_state[k] == 2));
    if (done) begin
      check({p, "_sb_depth"}, 32'(qs), 32'd1);
      if (qs > 0) m_hold[k] = (k == 0) ? q8.pop_front() : q2.pop_front();
    end
    check({p, "_sum"}, 32'(sum), 32'(m_hold[k] & mask));
    check({p, "_carry"}, 32'(co), 32'((m_hold[k] >> w) & 1));
    if (r) begin
      m_state[k] = 0;
      m_cnt[k]   = 0;
      m_hold[k]  = 0;
      if (k == 0) q8.delete(); else q2.delete();
    end else begin
      case (m_state[k])
        1: begin
          m_cnt[k]--;
          if (m_cnt[k] == 0) m_state[k] = 2;
        end
        default: begin
          if (st) begin
            if (k == 0) q8.push_back((int'(a) & mask) + (int'(b) & mask));
            else        q2.push_back((int'(a) & mask) + (int'(b) & mask));
            m_state[k] = 1;
            m_cnt[k]   = w;
          end else begin
            m_state[k] = 0;
          end
        end
      endcase
    end
  endtask

  always @(negedge clk) begin
    mon(0, busy8, done8, sum8, co8, rst, st8, a8, b8);
    mon(1, busy2, done2, {6'b0, sum2}, co2, rst, st2, {6'b0, a2}, {6'b0, b2});
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b);
    @(posedge clk); #2;
    st8 = 1'b1; a8 = a; b8 = b;
    @(posedge clk); #2;
    st8 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic rand8();
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #2;
      st8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
      @(posedge clk); #2;
      st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      repeat (6 + $urandom_range(0, 3)) @(posedge clk);
    end
  endtask

  task automatic rand2();
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #2;
      st2 = 1'b1; a2 = 2'($urandom); b2 = 2'($urandom);
      @(posedge clk); #2;
      st2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; st8 = 1'b0; st2 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; a2 = 2'b00; b2 = 2'b00;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    op8(8'h5A, 8'h3C); idle(10);
    check("dir_5a_3c_sum", 32'(sum8), 32'h96);
    check("dir_5a_3c_carry", 32'(co8), 32'd0);
    op8(8'hFF, 8'h01); idle(10);
    check("dir_ff_01_sum", 32'(sum8), 32'h00);
    check("dir_ff_01_carry", 32'(co8), 32'd1);
    op8(8'hFF, 8'hFF); idle(10);
    check("dir_ff_ff_sum", 32'(sum8), 32'hFE);
    op8(8'h00, 8'h00); idle(10);
    check("dir_00_00_carry", 32'(co8), 32'd0);

    // second start lands mid-RUN and must be ignored
    op8(8'h12, 8'h34); idle(2); op8(8'hFF, 8'hFF); idle(12);
    check("dir_ignore_sum", 32'(sum8), 32'h46);

    @(posedge clk); #2;
    st8 = 1'b1; a8 = 8'h80; b8 = 8'h80;
    repeat (30) @(posedge clk);
    #2 st8 = 1'b0;
    idle(12);
    check("dir_held_carry", 32'(co8), 32'd1);

    op8(8'hAA, 8'h55); idle(2);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    check("dir_rst_sum", 32'(sum8), 32'h00);
    check("dir_rst_busy", 32'(busy8), 32'd0);
    op8(8'hAA, 8'h55); idle(10);
    check("dir_aa_55_sum", 32'(sum8), 32'hFF);
    check("dir_aa_55_carry", 32'(co8), 32'd0);

    fork
      rand8();
      rand2();
    join
    idle(15);
    check("w8_sb_drain", 32'(q8.size()), 32'd0);
    check("w2_sb_drain", 32'(q2.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
